instr_decoder: RTL and testbench
================================

# instr_decoder

Registered RV32I instruction-decode stage that sits directly upstream of the ALU. It accepts one fetched instruction per cycle over a valid/ready handshake and splits it into register addresses, a sign-extended immediate, operand selects, the 4-bit ALU operation code, and memory/branch/writeback controls. Everything is held in a single-entry output pipeline register.

## Interface
- DATA_WIDTH, 32, width of the immediate and PC datapath
- clk  in  1  clock; all state updates on rising edge
- rstN  in  1  asynchronous, active-low reset
- flush  in  1  discard the held entry and any instruction accepted this cycle
- inValid  in  1  instrIn/pcIn valid
- inReady  out  1  stage can accept this cycle
- instrIn  in  32  raw instruction
- pcIn  in  DATA_WIDTH  instruction address
- outValid  out  1  decoded entry valid
- outReady  in  1  downstream consumes the entry this cycle
- aluOp  out  4  ALU op: 0000 eq, 0001 ne, 0010 lt, 0011 ge, 0100 ltu, 0101 geu, 0110 add, 0111 xor, 1000 or, 1001 and, 1010 sub, 1011 sll, 1100 srl, 1101 sra
- srcASel  out  2  ALU dataIn0 source: 00 rs1, 01 pc, 10 zero
- srcBSel  out  1  ALU dataIn1 source: 0 rs2, 1 imm
- rs1Addr, rs2Addr, rdAddr  out  5 each  raw instr[19:15], [24:20], [11:7]
- imm  out  DATA_WIDTH  sign-extended immediate (I/S/B/U/J per opcode; 0 for R-type)
- pcOut  out  DATA_WIDTH  pcIn of the held entry
- regWrite, memRead, memWrite, isBranch, isJump  out  1 each  control flags
- memSize  out  3  funct3 for loads/stores, else 0
- sltWb  out  1  writeback takes ALU result bit 0 zero-extended (SLT/SLTI/SLTU/SLTIU)
- illegal  out  1  unsupported encoding

## Operation
- inReady = !outValid || outReady (combinational). Accept when inValid && inReady.
- Accept without flush: all outputs load the decoded fields; outValid <= 1.
- outValid && outReady with no accept: outValid <= 0; data outputs hold their last values.
- While outValid && !outReady, all outputs remain stable.
- flush: outValid <= 0 next cycle. It takes priority over a simultaneous accept, which is dropped.
- Decode rules, with all flags 0 unless listed:
  - LUI 0110111: add, A=zero, B=imm(U), regWrite.
  - AUIPC 0010111: add, A=pc, B=imm(U), regWrite.
  - JAL 1101111: add, A=pc, B=imm(J), isJump, regWrite.
  - JALR 1100111 (funct3 must be 000): add, A=rs1, B=imm(I), isJump, regWrite.
  - BRANCH 1100011: A=rs1, B=rs2, imm(B), isBranch. funct3 map: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; 010/011 illegal.
  - LOAD 0000011: add, A=rs1, B=imm(I), memRead, regWrite. funct3 000/001/010/100/101 legal; others illegal.
  - STORE 0100011: add, A=rs1, B=imm(S), memWrite. funct3 000/001/010 legal.
  - OP-IMM 0010011: B=imm(I), A=rs1, regWrite. Ops: ADDI add, SLTI lt+sltWb, SLTIU ltu+sltWb, XORI, ORI, ANDI. SLLI requires funct7 0000000. SRLI (funct7 0000000) → srl; SRAI (funct7 0100000) → sra.
  - OP 0110011: A=rs1, B=rs2, regWrite. funct7 0000000 gives add/sll/slt/sltu/xor/srl/or/and; funct7 0100000 is legal only for funct3 000 sub and 101 sra.
  - Any other opcode, funct3, or funct7 combination: illegal=1, with regWrite, memRead, memWrite, isBranch, isJump, and sltWb forced to 0. The entry still passes with outValid=1.
- Immediates are sign-extended from instr[31] to DATA_WIDTH.

## Timing
- Latency: 1 cycle from accept to outValid. Throughput: 1 per cycle while outReady=1.
- Reset (rstN low, asynchronous): outValid=0 and every data/control output is 0 (aluOp 0000, srcASel 00, imm 0, pcOut 0). inReady=1 during and after reset.
- Reset while an entry is held discards it immediately. The first accept is possible on the first rising edge with rstN high.
- Simultaneous consume and accept on the same edge: the new entry replaces the old one, and outValid stays 1 with no bubble.

## Test plan
- ADDI x1,x2,-1 (0xFFF10093), pc 0x100 → next cycle: outValid 1, aluOp 0110, rs1 2, rd 1, imm 0xFFFFFFFF, srcASel 00, srcBSel 1, regWrite 1, pcOut 0x100.
- SUB x3,x1,x2 (0x402081B3) → aluOp 1010, srcBSel 0, rs1 1, rs2 2, rd 3, regWrite 1. SLTIU x5,x6,1 (0x00133293) → aluOp 0100, sltWb 1, imm 1.
- BLT x1,x2,-4 (0xFE20CEE3) → aluOp 0010, isBranch 1, imm 0xFFFFFFFC, regWrite 0.
- Backpressure: hold outReady=0 for 3 cycles with a second instruction on inValid → outputs stable, inReady 0. When outReady rises: same-edge swap to the second entry with no bubble.
- 0x00000000 and funct7 0100000 on XOR (0x4020C1B3) → illegal 1 with all control flags 0. Separately: flush coincident with an accept → outValid 0 next cycle. rstN pulse mid-stream → outValid drops immediately and all outputs are 0.

Source files
------------

// File: rtl/instr_decoder_if.sv
// Fetch-to-decode and decode-to-ALU signals for instr_decoder.
// The slave side is the decode stage; the master side is its environment.
interface instr_decoder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  flush;
    logic                  inValid;
    logic                  inReady;
    logic [31:0]           instrIn;
    logic [DATA_WIDTH-1:0] pcIn;

    logic                  outValid;
    logic                  outReady;
    logic [3:0]            aluOp;
    logic [1:0]            srcASel;
    logic                  srcBSel;
    logic [4:0]            rs1Addr;
    logic [4:0]            rs2Addr;
    logic [4:0]            rdAddr;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pcOut;
    logic                  regWrite;
    logic                  memRead;
    logic                  memWrite;
    logic                  isBranch;
    logic                  isJump;
    logic [2:0]            memSize;
    logic                  sltWb;
    logic                  illegal;

    modport slave (
        input  flush, inValid, instrIn, pcIn, outReady,
        output inReady, outValid, aluOp, srcASel, srcBSel,
               rs1Addr, rs2Addr, rdAddr, imm, pcOut,
               regWrite, memRead, memWrite, isBranch, isJump,
               memSize, sltWb, illegal
    );

    modport master (
        output flush, inValid, instrIn, pcIn, outReady,
        input  inReady, outValid, aluOp, srcASel, srcBSel,
               rs1Addr, rs2Addr, rdAddr, imm, pcOut,
               regWrite, memRead, memWrite, isBranch, isJump,
               memSize, sltWb, illegal
    );
endinterface

// File: rtl/instr_decoder.sv
// RV32I decode stage: combinational field/control decode feeding a
// single-entry valid/ready output register in front of the ALU.
module instr_decoder #(
    parameter int DATA_WIDTH = 32
) (
    input logic            clk,
    input logic            rstN,
    instr_decoder_if.slave bus
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_EQ  = 4'b0000;
    localparam logic [3:0] ALU_NE  = 4'b0001;
    localparam logic [3:0] ALU_LT  = 4'b0010;
    localparam logic [3:0] ALU_GE  = 4'b0011;
    localparam logic [3:0] ALU_LTU = 4'b0100;
    localparam logic [3:0] ALU_GEU = 4'b0101;
    localparam logic [3:0] ALU_ADD = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_OR  = 4'b1000;
    localparam logic [3:0] ALU_AND = 4'b1001;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam logic [3:0] ALU_SLL = 4'b1011;
    localparam logic [3:0] ALU_SRL = 4'b1100;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;

    logic [3:0]         dec_alu_op;
    logic [1:0]         dec_src_a;
    logic               dec_src_b;
    logic signed [31:0] dec_imm;
    logic               dec_reg_write;
    logic               dec_mem_read;
    logic               dec_mem_write;
    logic               dec_branch;
    logic               dec_jump;
    logic [2:0]         dec_mem_size;
    logic               dec_slt_wb;
    logic               dec_illegal;

    logic                  in_ready;
    logic                  load;
    logic                  out_valid_d,  out_valid_q;
    logic [3:0]            alu_op_d,     alu_op_q;
    logic [1:0]            src_a_sel_d,  src_a_sel_q;
    logic                  src_b_sel_d,  src_b_sel_q;
    logic [4:0]            rs1_addr_d,   rs1_addr_q;
    logic [4:0]            rs2_addr_d,   rs2_addr_q;
    logic [4:0]            rd_addr_d,    rd_addr_q;
    logic [DATA_WIDTH-1:0] imm_d,        imm_q;
    logic [DATA_WIDTH-1:0] pc_out_d,     pc_out_q;
    logic                  reg_write_d,  reg_write_q;
    logic                  mem_read_d,   mem_read_q;
    logic                  mem_write_d,  mem_write_q;
    logic                  is_branch_d,  is_branch_q;
    logic                  is_jump_d,    is_jump_q;
    logic [2:0]            mem_size_d,   mem_size_q;
    logic                  slt_wb_d,     slt_wb_q;
    logic                  illegal_d,    illegal_q;

    assign opcode = bus.instrIn[6:0];
    assign funct3 = bus.instrIn[14:12];
    assign funct7 = bus.instrIn[31:25];

    assign imm_i = {{20{bus.instrIn[31]}}, bus.instrIn[31:20]};
    assign imm_s = {{20{bus.instrIn[31]}}, bus.instrIn[31:25], bus.instrIn[11:7]};
    assign imm_b = {{19{bus.instrIn[31]}}, bus.instrIn[31], bus.instrIn[7],
                    bus.instrIn[30:25], bus.instrIn[11:8], 1'b0};
    assign imm_u = {bus.instrIn[31:12], 12'b0};
    assign imm_j = {{11{bus.instrIn[31]}}, bus.instrIn[31], bus.instrIn[19:12],
                    bus.instrIn[20], bus.instrIn[30:21], 1'b0};

    always_comb begin
        dec_alu_op    = ALU_ADD;
        dec_src_a     = SRC_A_RS1;
        dec_src_b     = 1'b0;
        dec_imm       = '0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_mem_size  = 3'b000;
        dec_slt_wb    = 1'b0;
        dec_illegal   = 1'b0;

        case (opcode)
            OPC_LUI: begin
                dec_src_a     = SRC_A_ZERO;
                dec_src_b     = 1'b1;
                dec_imm       = imm_u;
                dec_reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec_src_a     = SRC_A_PC;
                dec_src_b     = 1'b1;
                dec_imm       = imm_u;
                dec_reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec_src_a     = SRC_A_PC;
                dec_src_b     = 1'b1;
                dec_imm       = imm_j;
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
            end
            OPC_JALR: begin
                dec_src_b     = 1'b1;
                dec_imm       = imm_i;
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
                dec_illegal   = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_imm    = imm_b;
                dec_branch = 1'b1;
                case (funct3)
                    3'b000:  dec_alu_op = ALU_EQ;
                    3'b001:  dec_alu_op = ALU_NE;
                    3'b100:  dec_alu_op = ALU_LT;
                    3'b101:  dec_alu_op = ALU_GE;
                    3'b110:  dec_alu_op = ALU_LTU;
                    3'b111:  dec_alu_op = ALU_GEU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_src_b     = 1'b1;
                dec_imm       = imm_i;
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
                dec_mem_size  = funct3;
                dec_illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                                (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec_src_b     = 1'b1;
                dec_imm       = imm_s;
                dec_mem_write = 1'b1;
                dec_mem_size  = funct3;
                dec_illegal   = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                dec_src_b     = 1'b1;
                dec_imm       = imm_i;
                dec_reg_write = 1'b1;
                case (funct3)
                    3'b000: dec_alu_op = ALU_ADD;
                    3'b010: begin
                        dec_alu_op = ALU_LT;
                        dec_slt_wb = 1'b1;
                    end
                    3'b011: begin
                        dec_alu_op = ALU_LTU;
                        dec_slt_wb = 1'b1;
                    end
                    3'b100: dec_alu_op = ALU_XOR;
                    3'b110: dec_alu_op = ALU_OR;
                    3'b111: dec_alu_op = ALU_AND;
                    3'b001: begin
                        dec_alu_op  = ALU_SLL;
                        dec_illegal = (funct7 != F7_BASE);
                    end
                    default: begin
                        // funct3 101: funct7 picks logical vs arithmetic shift
                        if (funct7 == F7_BASE) begin
                            dec_alu_op = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_alu_op = ALU_SRA;
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                endcase
            end
            OPC_OP: begin
                dec_reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000: dec_alu_op = ALU_ADD;
                        3'b001: dec_alu_op = ALU_SLL;
                        3'b010: begin
                            dec_alu_op = ALU_LT;
                            dec_slt_wb = 1'b1;
                        end
                        3'b011: begin
                            dec_alu_op = ALU_LTU;
                            dec_slt_wb = 1'b1;
                        end
                        3'b100:  dec_alu_op = ALU_XOR;
                        3'b101:  dec_alu_op = ALU_SRL;
                        3'b110:  dec_alu_op = ALU_OR;
                        default: dec_alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_alu_op = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase

        // An illegal entry still flows downstream but must not cause side effects
        if (dec_illegal) begin
            dec_reg_write = 1'b0;
            dec_mem_read  = 1'b0;
            dec_mem_write = 1'b0;
            dec_branch    = 1'b0;
            dec_jump      = 1'b0;
            dec_slt_wb    = 1'b0;
        end
    end

    assign in_ready = !out_valid_q || bus.outReady;
    assign load     = bus.inValid && in_ready && !bus.flush;

    always_comb begin
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
        end else if (bus.outReady) begin
            out_valid_d = 1'b0;
        end

        alu_op_d    = alu_op_q;
        src_a_sel_d = src_a_sel_q;
        src_b_sel_d = src_b_sel_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        imm_d       = imm_q;
        pc_out_d    = pc_out_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        is_branch_d = is_branch_q;
        is_jump_d   = is_jump_q;
        mem_size_d  = mem_size_q;
        slt_wb_d    = slt_wb_q;
        illegal_d   = illegal_q;

        if (load) begin
            alu_op_d    = dec_alu_op;
            src_a_sel_d = dec_src_a;
            src_b_sel_d = dec_src_b;
            rs1_addr_d  = bus.instrIn[19:15];
            rs2_addr_d  = bus.instrIn[24:20];
            rd_addr_d   = bus.instrIn[11:7];
            imm_d       = DATA_WIDTH'(dec_imm);
            pc_out_d    = bus.pcIn;
            reg_write_d = dec_reg_write;
            mem_read_d  = dec_mem_read;
            mem_write_d = dec_mem_write;
            is_branch_d = dec_branch;
            is_jump_d   = dec_jump;
            mem_size_d  = dec_mem_size;
            slt_wb_d    = dec_slt_wb;
            illegal_d   = dec_illegal;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_valid_q <= 1'b0;
            alu_op_q    <= '0;
            src_a_sel_q <= '0;
            src_b_sel_q <= 1'b0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            imm_q       <= '0;
            pc_out_q    <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            is_branch_q <= 1'b0;
            is_jump_q   <= 1'b0;
            mem_size_q  <= '0;
            slt_wb_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_op_q    <= alu_op_d;
            src_a_sel_q <= src_a_sel_d;
            src_b_sel_q <= src_b_sel_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            imm_q       <= imm_d;
            pc_out_q    <= pc_out_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            is_branch_q <= is_branch_d;
            is_jump_q   <= is_jump_d;
            mem_size_q  <= mem_size_d;
            slt_wb_q    <= slt_wb_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.inReady  = in_ready;
    assign bus.outValid = out_valid_q;
    assign bus.aluOp    = alu_op_q;
    assign bus.srcASel  = src_a_sel_q;
    assign bus.srcBSel  = src_b_sel_q;
    assign bus.rs1Addr  = rs1_addr_q;
    assign bus.rs2Addr  = rs2_addr_q;
    assign bus.rdAddr   = rd_addr_q;
    assign bus.imm      = imm_q;
    assign bus.pcOut    = pc_out_q;
    assign bus.regWrite = reg_write_q;
    assign bus.memRead  = mem_read_q;
    assign bus.memWrite = mem_write_q;
    assign bus.isBranch = is_branch_q;
    assign bus.isJump   = is_jump_q;
    assign bus.memSize  = mem_size_q;
    assign bus.sltWb    = slt_wb_q;
    assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Scoreboard bench for instr_decoder: the driver queues hand-computed decodes
// on accept, and a monitor compares them as entries are consumed.
module tb_instr_decoder;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  alu_op;
        logic [1:0]  src_a;
        logic        src_b;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [4:0]  flags;
        logic [2:0]  mem_size;
        logic        slt_wb;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rstN;
    int   num_checks = 0;
    int   num_fails  = 0;
    exp_t exp_q[$];

    instr_decoder_if #(.DATA_WIDTH(32)) bus ();

    instr_decoder #(.DATA_WIDTH(32)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // flags packs {regWrite, memRead, memWrite, isBranch, isJump}
    function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] alu,
                                input logic [1:0] a, input logic b,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm,
                                input logic [4:0] flags, input logic [2:0] msize,
                                input logic slt, input logic ill);
        exp_t e;
        e.pc = pc; e.alu_op = alu; e.src_a = a; e.src_b = b;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
        e.flags = flags; e.mem_size = msize; e.slt_wb = slt; e.illegal = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        num_checks++;
        if (act !== req) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_output(input exp_t e);
        chk("illegal", 32'(bus.illegal), 32'(e.illegal));
        chk("flags", 32'({bus.regWrite, bus.memRead, bus.memWrite, bus.isBranch, bus.isJump}),
            32'(e.flags));
        chk("sltWb", 32'(bus.sltWb), 32'(e.slt_wb));
        chk("rs1Addr", 32'(bus.rs1Addr), 32'(e.rs1));
        chk("rs2Addr", 32'(bus.rs2Addr), 32'(e.rs2));
        chk("rdAddr", 32'(bus.rdAddr), 32'(e.rd));
        chk("pcOut", bus.pcOut, e.pc);
        if (!e.illegal) begin
            chk("aluOp", 32'(bus.aluOp), 32'(e.alu_op));
            chk("srcASel", 32'(bus.srcASel), 32'(e.src_a));
            chk("srcBSel", 32'(bus.srcBSel), 32'(e.src_b));
            chk("imm", bus.imm, e.imm);
            chk("memSize", 32'(bus.memSize), 32'(e.mem_size));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rstN === 1'b1 && bus.outValid === 1'b1 && bus.outReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                num_checks++;
                num_fails++;
                $display("[TB] FAIL unexpected_entry: outValid 1 at pc 0x%0h, required no entry",
                         bus.pcOut);
            end else begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    // Called at the drive point (1 time unit after a rising edge); returns at
    // the drive point following the accepting edge.
    task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        bit accepted = 1'b0;
        bus.inValid = 1'b1;
        bus.instrIn = instr;
        bus.pcIn    = pc;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (bus.inReady === 1'b1) begin
                accepted = 1'b1;
                if (!bus.flush) exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        bus.inValid = 1'b0;
        if (!accepted) begin
            num_checks++;
            num_fails++;
            $display("[TB] FAIL accept_timeout: instr 0x%08h inReady %0b, required 1",
                     instr, bus.inReady);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (exp_q.size() == 0 && bus.outValid === 1'b0) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        num_checks++;
        if (!done) begin
            num_fails++;
            $display("[TB] FAIL drain_timeout: %0d entries pending, outValid %0b, required 0 and 0",
                     exp_q.size(), bus.outValid);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e_lui;
        rstN         = 1'b0;
        bus.flush    = 1'b0;
        bus.inValid  = 1'b0;
        bus.instrIn  = '0;
        bus.pcIn     = '0;
        bus.outReady = 1'b1;

        @(posedge clk);
        #1;
        chk("rst_outValid", 32'(bus.outValid), 32'd0);
        chk("rst_inReady", 32'(bus.inReady), 32'd1);
        chk("rst_aluOp", 32'(bus.aluOp), 32'd0);
        chk("rst_imm", bus.imm, 32'd0);
        chk("rst_pcOut", bus.pcOut, 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        chk("post_rst_inReady", 32'(bus.inReady), 32'd1);

        // ADDI x1,x2,-1: also checks the one-cycle latency
        apply_stimulus(32'hFFF10093, 32'h100,
                       mk(32'h100, 4'b0110, 2'b00, 1'b1, 5'd2, 5'd31, 5'd1,
                          32'hFFFFFFFF, 5'b10000, 3'd0, 1'b0, 1'b0));
        chk("latency_outValid", 32'(bus.outValid), 32'd1);

        // Back-to-back stream at full throughput
        apply_stimulus(32'h402081B3, 32'h104,
                       mk(32'h104, 4'b1010, 2'b00, 1'b0, 5'd1, 5'd2, 5'd3,
                          32'h0, 5'b10000, 3'd0, 1'b0, 1'b0));
        apply_stimulus(32'h00133293, 32'h108,
                       mk(32'h108, 4'b0100, 2'b00, 1'b1, 5'd6, 5'd1, 5'd5,
                          32'h1, 5'b10000, 3'd0, 1'b1, 1'b0));
        apply_stimulus(32'hFE20CEE3, 32'h10C,
                       mk(32'h10C, 4'b0010, 2'b00, 1'b0, 5'd1, 5'd2, 5'd29,
                          32'hFFFFFFFC, 5'b00010, 3'd0, 1'b0, 1'b0));
        apply_stimulus(32'h00812303, 32'h110,
                       mk(32'h110, 4'b0110, 2'b00, 1'b1, 5'd2, 5'd8, 5'd6,
                          32'h8, 5'b11000, 3'd2, 1'b0, 1'b0));
        apply_stimulus(32'h0050A623, 32'h114,
                       mk(32'h114, 4'b0110, 2'b00, 1'b1, 5'd1, 5'd5, 5'd12,
                          32'hC, 5'b00100, 3'd2, 1'b0, 1'b0));
        apply_stimulus(32'h008000EF, 32'h118,
                       mk(32'h118, 4'b0110, 2'b01, 1'b1, 5'd0, 5'd8, 5'd1,
                          32'h8, 5'b10001, 3'd0, 1'b0, 1'b0));
        apply_stimulus(32'h40325213, 32'h11C,
                       mk(32'h11C, 4'b1101, 2'b00, 1'b1, 5'd4, 5'd3, 5'd4,
                          32'h403, 5'b10000, 3'd0, 1'b0, 1'b0));
        apply_stimulus(32'h00000000, 32'h120,
                       mk(32'h120, 4'b0000, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0,
                          32'h0, 5'b00000, 3'd0, 1'b0, 1'b1));
        apply_stimulus(32'h4020C1B3, 32'h124,
                       mk(32'h124, 4'b0000, 2'b00, 1'b0, 5'd1, 5'd2, 5'd3,
                          32'h0, 5'b00000, 3'd0, 1'b0, 1'b1));
        wait_drain();

        // Backpressure: LUI held while SRAI waits, then a same-edge swap
        $display("[TB] backpressure sequence");
        e_lui = mk(32'h200, 4'b0110, 2'b10, 1'b1, 5'd8, 5'd3, 5'd5,
                   32'h12345000, 5'b10000, 3'd0, 1'b0, 1'b0);
        bus.outReady = 1'b0;
        apply_stimulus(32'h123452B7, 32'h200, e_lui);
        fork
            apply_stimulus(32'h40325213, 32'h204,
                           mk(32'h204, 4'b1101, 2'b00, 1'b1, 5'd4, 5'd3, 5'd4,
                              32'h403, 5'b10000, 3'd0, 1'b0, 1'b0));
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("bp_outValid", 32'(bus.outValid), 32'd1);
                    chk("bp_inReady", 32'(bus.inReady), 32'd0);
                    chk("bp_aluOp", 32'(bus.aluOp), 32'(e_lui.alu_op));
                    chk("bp_imm", bus.imm, e_lui.imm);
                    chk("bp_pcOut", bus.pcOut, e_lui.pc);
                end
                @(posedge clk);
                #1;
                bus.outReady = 1'b1;
            end
        join
        chk("swap_outValid", 32'(bus.outValid), 32'd1);
        chk("swap_pcOut", bus.pcOut, 32'h204);
        wait_drain();

        // Flush coincident with an accept drops the new instruction
        bus.flush = 1'b1;
        apply_stimulus(32'hFFF10093, 32'h300,
                       mk(32'h300, 4'b0110, 2'b00, 1'b1, 5'd2, 5'd31, 5'd1,
                          32'hFFFFFFFF, 5'b10000, 3'd0, 1'b0, 1'b0));
        bus.flush = 1'b0;
        chk("flush_accept_outValid", 32'(bus.outValid), 32'd0);

        // Flush of a held entry
        bus.outReady = 1'b0;
        apply_stimulus(32'h402081B3, 32'h304,
                       mk(32'h304, 4'b1010, 2'b00, 1'b0, 5'd1, 5'd2, 5'd3,
                          32'h0, 5'b10000, 3'd0, 1'b0, 1'b0));
        chk("held_outValid", 32'(bus.outValid), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        exp_q.delete();
        chk("flush_held_outValid", 32'(bus.outValid), 32'd0);

        // Asynchronous reset while an entry is held
        apply_stimulus(32'h008000EF, 32'h308,
                       mk(32'h308, 4'b0110, 2'b01, 1'b1, 5'd0, 5'd8, 5'd1,
                          32'h8, 5'b10001, 3'd0, 1'b0, 1'b0));
        chk("pre_rst_isJump", 32'(bus.isJump), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_outValid", 32'(bus.outValid), 32'd0);
        chk("mid_rst_inReady", 32'(bus.inReady), 32'd1);
        chk("mid_rst_aluOp", 32'(bus.aluOp), 32'd0);
        chk("mid_rst_srcASel", 32'(bus.srcASel), 32'd0);
        chk("mid_rst_imm", bus.imm, 32'd0);
        chk("mid_rst_pcOut", bus.pcOut, 32'd0);
        chk("mid_rst_rdAddr", 32'(bus.rdAddr), 32'd0);
        chk("mid_rst_flags", 32'({bus.regWrite, bus.memRead, bus.memWrite, bus.isBranch,
                                  bus.isJump}), 32'd0);
        @(posedge clk);
        #1;
        rstN         = 1'b1;
        bus.outReady = 1'b1;

        // First accept after reset release
        apply_stimulus(32'h00133293, 32'h400,
                       mk(32'h400, 4'b0100, 2'b00, 1'b1, 5'd6, 5'd1, 5'd5,
                          32'h1, 5'b10000, 3'd0, 1'b1, 1'b0));
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
        $finish;
    end

endmodule
